// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    FIN
  } state_t;

  localparam int IMEM_DEPTH          = 256;
  localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

endpackage

// File: rtl/imem_loader.sv
// Loads a framed image (length, payload, checksum) from a byte stream into instruction memory.
// Latency: payload byte accepted at edge k is written during cycle k+1; status updates on checksum accept.
// Backpressure: rx_ready is a pure state decode (LEN/DATA/CSUM); the source holds bytes otherwise.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_w_data,
  output logic       mem_w_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       cpu_hold
);

  state_t     state_q;
  state_t     state_d;
  logic [8:0] remaining_q;
  logic [7:0] next_addr_q;
  logic [7:0] sum_q;
  logic       accept;

  assign accept = rx_valid & rx_ready;
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (remaining_q == 9'd1)) state_d = CSUM;
      end
      CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_addr is only updated on a write, so it holds the last written address between writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q <= 9'd0;
      next_addr_q <= 8'd0;
      sum_q       <= 8'd0;
      mem_addr    <= 8'd0;
      mem_w_data  <= 8'd0;
      mem_w_en    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_hold    <= 1'b1;
    end else begin
      mem_w_en <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            next_addr_q <= 8'd0;
            sum_q       <= 8'd0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_hold    <= 1'b1;
          end
        end
        LEN: begin
          if (accept) begin
            if (LEN_ZERO_MEANS_FULL && (rx_data == 8'd0))
              remaining_q <= 9'(IMEM_DEPTH);
            else
              remaining_q <= {1'b0, rx_data};
          end
        end
        DATA: begin
          if (accept) begin
            mem_addr    <= next_addr_q;
            mem_w_data  <= rx_data;
            mem_w_en    <= 1'b1;
            next_addr_q <= next_addr_q + 8'd1;
            sum_q       <= sum_q + rx_data;
            remaining_q <= remaining_q - 9'd1;
          end
        end
        CSUM: begin
          if (accept) begin
            if (rx_data == sum_q) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a driver issues frames and queues expected writes; a monitor checks them.
module tb_imem_loader;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_w_data;
  logic       mem_w_en;
  logic       busy;
  logic       done;
  logic       error;
  logic       cpu_hold;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  img[$];

  imem_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_w_en   (mem_w_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next queued {addr, data}.
  always @(negedge clock) begin
    if (reset_n && mem_w_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_w_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_w_data} != e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                   mem_addr, mem_w_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input bit gaps);
    int  n;
    bit  sent;
    n    = 0;
    sent = 1'b0;
    while (!sent) begin
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        rx_valid = 1'b0;
        check("rdy_in_data", int'(rx_ready), 1);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready) sent = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      n++;
      if (!sent && n > 200) begin
        check("send_timeout", 0, 1);
        sent = 1'b1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Sends img as a complete frame; payload writes are queued before the bytes go out.
  task automatic run_load(input bit gaps);
    int n;
    n = (img[0] == 8'd0) ? 256 : int'(img[0]);
    pulse_start();
    send(img[0], 1'b0);
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back({8'(i - 1), img[i]});
      send(img[i], gaps);
    end
    send(img[n + 1], 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_w_data), 0);
    check("rst_wen", int'(mem_w_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_hold", int'(cpu_hold), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rdy", int'(rx_ready), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Nominal load
    img = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    run_load(1'b0);
    check("nom_done_fin", int'(done), 1);
    check("nom_hold_fin", int'(cpu_hold), 0);
    check("nom_busy_fin", int'(busy), 1);
    pulse_start();  // lands in FIN, must be ignored
    check("nom_busy", int'(busy), 0);
    check("nom_done", int'(done), 1);
    check("nom_error", int'(error), 0);
    check("nom_hold", int'(cpu_hold), 0);
    check("nom_all_written", exp_q.size(), 0);

    // Bad checksum
    img = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h32};
    run_load(1'b0);
    @(negedge clock);
    check("bad_done", int'(done), 0);
    check("bad_error", int'(error), 1);
    check("bad_hold", int'(cpu_hold), 1);
    check("bad_busy", int'(busy), 0);
    check("bad_all_written", exp_q.size(), 0);

    // Full 256-byte image
    img = {};
    img.push_back(8'h00);
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    img.push_back(8'h80);
    run_load(1'b0);
    check("full_addr", int'(mem_addr), 8'hFF);
    check("full_done", int'(done), 1);
    check("full_hold", int'(cpu_hold), 0);
    @(negedge clock);
    check("full_busy", int'(busy), 0);
    check("full_all_written", exp_q.size(), 0);

    // Payload with rx_valid gaps
    img = '{8'h02, 8'h11, 8'h22, 8'h33};
    run_load(1'b1);
    @(negedge clock);
    check("gap_done", int'(done), 1);
    check("gap_error", int'(error), 0);
    check("gap_all_written", exp_q.size(), 0);

    // start pulsed mid-DATA is ignored
    pulse_start();
    send(8'h03, 1'b0);
    exp_q.push_back({8'h00, 8'h01});
    send(8'h01, 1'b0);
    pulse_start();
    check("mid_start_busy", int'(busy), 1);
    exp_q.push_back({8'h01, 8'h02});
    send(8'h02, 1'b0);
    exp_q.push_back({8'h02, 8'h03});
    send(8'h03, 1'b0);
    send(8'h06, 1'b0);
    @(negedge clock);
    check("mid_start_done", int'(done), 1);
    check("mid_start_all_written", exp_q.size(), 0);

    // Bytes offered while idle are not accepted
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("idle_rdy", int'(rx_ready), 0);
      @(negedge clock);
    end
    rx_valid = 1'b0;
    check("idle_busy", int'(busy), 0);

    // Async reset after 2 of 4 payload bytes
    pulse_start();
    send(8'h04, 1'b0);
    exp_q.push_back({8'h00, 8'h10});
    send(8'h10, 1'b0);
    exp_q.push_back({8'h01, 8'h20});
    send(8'h20, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_addr", int'(mem_addr), 0);
    check("arst_wdata", int'(mem_w_data), 0);
    check("arst_wen", int'(mem_w_en), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_hold", int'(cpu_hold), 1);
    check("arst_rdy", int'(rx_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("arst_partial_written", exp_q.size(), 0);
    img = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_load(1'b0);
    @(negedge clock);
    check("reload_done", int'(done), 1);
    check("reload_hold", int'(cpu_hold), 0);
    check("reload_all_written", exp_q.size(), 0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the 256×8 instruction memory from a byte stream (UART receiver output) before the jacaranda-8 core runs. It accepts a framed image (length, payload, checksum), drives the memory write port (address, write data, write enable), and holds the core in reset until a load completes with a matching checksum. It sits between the UART RX byte interface and the instruction memory write port; an external mux selects its address while `cpu_hold` is high.

## Interface
Parameters:
- none; widths fixed by the 8-bit core (256-entry, 8-bit instruction memory).

Ports:
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load; ignored while busy.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` valid.
- `rx_ready` output 1: loader accepts a byte this cycle; a byte transfers when `rx_valid & rx_ready`.
- `mem_addr` output 8: write address to instruction memory.
- `mem_w_data` output 8: write data.
- `mem_w_en` output 1: write strobe, one cycle per payload byte.
- `busy` output 1: a load is in progress.
- `done` output 1: last load finished with a good checksum; level signal.
- `error` output 1: last load finished with a bad checksum; level signal.
- `cpu_hold` output 1: keeps the core in reset.

## Operation
- States:
  - IDLE: waits for `start`.
  - LEN: accepts 1 byte = N. N=0 means 256. The remaining-count is 9 bits.
  - DATA: accepts N bytes. Each accepted byte is written to addresses 0,1,…,N-1 in order. An 8-bit running sum accumulates the bytes, wrapping mod 256.
  - CSUM: accepts 1 byte and compares it with the running sum.
  - FIN: one cycle, then returns to IDLE.
- State transitions:
  - IDLE→LEN on `start`. This clears the address counter, sum, `done` and `error`, and sets `cpu_hold`=1.
  - LEN→DATA on accept.
  - DATA→CSUM on accepting the byte that brings the remaining-count to 0.
  - CSUM→FIN on accept. Match sets `done`=1 and `cpu_hold`=0. Mismatch sets `error`=1 and leaves `cpu_hold`=1.
- `rx_ready` is a combinational decode of the state: 1 in LEN, DATA and CSUM; 0 in IDLE and FIN. It never depends on `rx_valid`.
- `busy` = state ≠ IDLE.
- Bytes arriving while in IDLE are not accepted; they remain the source's problem.
- `start` while busy is ignored. It does not restart the load.
- Address counter:
  - 8 bits; after address 255 (N=256) it wraps to 0, and no further write occurs.
  - `mem_addr` holds the last written address between writes.
- Reset values: state IDLE, `mem_addr`=0, `mem_w_data`=0, `mem_w_en`=0, `done`=0, `error`=0, `cpu_hold`=1, sum=0.
- Reset mid-load aborts immediately. Memory contents already written stay as written. `cpu_hold` stays 1 until a later successful load.

## Timing
- Byte accept in DATA at edge k drives `mem_addr`, `mem_w_data` and `mem_w_en`=1 (all registered) during cycle k+1. The memory captures the byte at edge k+1.
- `mem_w_en` is never high for two cycles for the same byte. Back-to-back accepts give consecutive write cycles with incrementing addresses.
- Throughput: one byte per cycle when `rx_valid` is held high.
- Checksum accept at edge k: `done`/`error` and `cpu_hold` update at edge k (visible cycle k+1); `busy` deasserts one cycle later (FIN).
- The last payload write (cycle after its accept) precedes or coincides with the CSUM accept, so memory is complete before `cpu_hold` falls.
- `start` in the same cycle as FIN is ignored; `start` in IDLE the next cycle is honoured.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LEN, DATA, CSUM, FIN);
  - constant `IMEM_DEPTH` = 256;
  - constant `LEN_ZERO_MEANS_FULL` = 1.
- Single module; no sub-module is warranted. The counter, sum and FSM are small enough to stay flat.

## Test plan
- Nominal load: `start`, bytes 03, AA, BB, CC, checksum 31 → writes AA@0, BB@1, CC@2 on consecutive cycles; `done`=1, `error`=0, `cpu_hold`=0, `busy`=0 two cycles after the checksum accept.
- Bad checksum: same image with checksum 32 → three writes occur; `error`=1, `done`=0, `cpu_hold`=1.
- Full image:
  - stimulus: length 00, then 256 bytes with value = index, then checksum 80 (sum of 0..255 mod 256);
  - required response: writes at addresses 0..255, `mem_addr` ends at FF, `done`=1.
- Backpressure/gaps: `rx_valid` toggled randomly during payload 02, 11, 22, checksum 33 → exactly 2 writes, `mem_w_en` high only in the cycle after each accept; `rx_ready` stays 1 throughout DATA.
- Ignored events:
  - `start` pulsed during DATA → no restart, addresses continue;
  - bytes presented in IDLE → `rx_ready`=0, no writes.
- Async reset mid-DATA after 2 of 4 bytes:
  - required response: all outputs immediately at reset values, `cpu_hold`=1;
  - a subsequent full load then succeeds from address 0.
